rst_seq: RTL and testbench

//  Reset sequencer for multi-domain designs: holds all downstream reset domains in reset,

---
 rtl/rst_seq_pkg.sv | 20 ++
 rtl/rst_seq_if.sv | 26 ++
 rtl/rst_seq_pf.sv | 21 ++
 rtl/rst_seq.sv | 138 +++++++++++++
 tb/tb_rst_seq.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {HOLD, REL, WAIT, GAP, DONE} rst_seq_state_t;

  // Counter must reach the largest of the three programmable intervals.
  function automatic int cnt_w(input int hold_cyc, input int gap_cyc, input int tmo_cyc);
    int m;
    m = hold_cyc;
    if (gap_cyc > m) m = gap_cyc;
    if (tmo_cyc > m) m = tmo_cyc;
    return $clog2(m + 1);
  endfunction

  // Stage index width; a single-stage build still gets a 1-bit index.
  function automatic int idx_w(input int n_stages);
    return (n_stages > 1) ? $clog2(n_stages) : 1;
  endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Sequencer-facing bundle: restart request, per-domain ready in, per-domain reset and status out.
interface rst_seq_if #(
  parameter int N_STAGES = 4
);
  import rst_seq_pkg::*;

  localparam int IW = idx_w(N_STAGES);

  logic                sw_req;
  logic [N_STAGES-1:0] rdy;
  logic [N_STAGES-1:0] rst_o;
  logic                done;
  logic                busy;
  logic                err;
  logic [IW-1:0]       err_stage;

  modport master (
    input  sw_req, rdy,
    output rst_o, done, busy, err, err_stage
  );

  modport slave (
    output sw_req, rdy,
    input  rst_o, done, busy, err, err_stage
  );
endinterface

// File: rtl/rst_seq_pf.sv
// Rising-edge pulse former: registered one-cycle pulse on each 0->1 of in_i.
module rst_seq_pf (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic pulse_o
);
  logic in_q, pulse_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      in_q    <= in_i;
      pulse_q <= in_i & ~in_q;
    end
  end

  assign pulse_o = pulse_q;
endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: holds every domain in reset, then releases them in index order,
// waiting for each domain's ready (or a timeout) plus a fixed gap before the next.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int N_STAGES = 4,
  parameter int HOLD_CYC = 8,
  parameter int GAP_CYC  = 16,
  parameter int TMO_CYC  = 1024
) (
  input  logic clk,
  input  logic rst,
  rst_seq_if.master bus
);
  localparam int CW = cnt_w(HOLD_CYC, GAP_CYC, TMO_CYC);
  localparam int IW = idx_w(N_STAGES);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TMO_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_STAGES - 1);

  rst_seq_state_t      state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [N_STAGES-1:0] rst_o_q, rst_o_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [IW-1:0]       err_stage_q, err_stage_d;
  logic                rp;

  rst_seq_pf u_pf (
    .clk    (clk),
    .rst    (rst),
    .in_i   (bus.sw_req),
    .pulse_o(rp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      idx_q       <= '0;
      rst_o_q     <= '1;
      done_q      <= 1'b0;
      busy_q      <= 1'b1;
      err_q       <= 1'b0;
      err_stage_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rst_o_q     <= rst_o_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      err_stage_q <= err_stage_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rst_o_d     = rst_o_q;
    err_d       = err_q;
    err_stage_d = err_stage_q;
    // Status flags trail the state by one register, so done rises the edge after DONE is entered.
    done_d      = (state_q == DONE);
    busy_d      = (state_q != DONE);

    if (rp) begin
      state_d     = HOLD;
      cnt_d       = '0;
      idx_d       = '0;
      rst_o_d     = '1;
      done_d      = 1'b0;
      busy_d      = 1'b1;
      err_d       = 1'b0;
      err_stage_d = '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = REL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        REL: begin
          rst_o_d[idx_q] = 1'b0;
          state_d        = WAIT;
          cnt_d          = '0;
        end
        WAIT: begin
          if (bus.rdy[idx_q]) begin
            state_d = GAP;
            cnt_d   = '0;
          end else if (cnt_q == TMO_LAST) begin
            // Timeout still advances; only the first failing stage is recorded.
            state_d = GAP;
            cnt_d   = '0;
            err_d   = 1'b1;
            if (!err_q) err_stage_d = idx_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_q + IW'(1);
              state_d = REL;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DONE: ;
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign bus.rst_o     = rst_o_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.err_stage = err_stage_q;
endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: event-timeline reference model checked every cycle, plus directed literal checks.
module tb_rst_seq;
  localparam int N    = 4;
  localparam int HOLD = 8;
  localparam int GAP  = 16;
  localparam int TMO  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   pos   = 0;

  rst_seq_if #(.N_STAGES(N)) bus ();

  rst_seq #(
    .N_STAGES(N), .HOLD_CYC(HOLD), .GAP_CYC(GAP), .TMO_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @pos %0d: got %0h want %0h", nm, pos, act, exp);
    end
  endtask

  // Reference: schedule of release edges counted from the start of the sequence.
  logic [N-1:0] m_rst_o;
  logic         m_done, m_err;
  logic [1:0]   m_es;
  int           m_t, m_stage, m_rel, m_done_e;
  bit           m_wait, sw_prev, rs_pend, armed;

  task automatic m_reset();
    m_rst_o  = '1;
    m_done   = 1'b0;
    m_err    = 1'b0;
    m_es     = '0;
    m_t      = 0;
    m_stage  = 0;
    m_rel    = HOLD + 1;
    m_wait   = 1'b0;
    m_done_e = -1;
  endtask

  task automatic m_step();
    m_t++;
    if (m_done_e >= 0) begin
      if (m_t == m_done_e) m_done = 1'b1;
    end else if (m_wait) begin
      if (bus.rdy[m_stage] || m_t == m_rel + TMO) begin
        if (!bus.rdy[m_stage]) begin
          if (!m_err) m_es = 2'(m_stage);
          m_err = 1'b1;
        end
        m_wait = 1'b0;
        if (m_stage == N - 1) m_done_e = m_t + GAP + 1;
        else begin
          m_stage++;
          m_rel = m_t + GAP + 1;
        end
      end
    end else if (m_t == m_rel) begin
      m_rst_o[m_stage] = 1'b0;
      m_wait = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_reset();
      sw_prev = 1'b0;
      rs_pend = 1'b0;
      armed   = 1'b1;
    end else begin
      if (rs_pend) m_reset();
      else         m_step();
      rs_pend = bus.sw_req && !sw_prev;
      sw_prev = bus.sw_req;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("m_rst_o",     bus.rst_o,     m_rst_o);
      chk("m_done",      bus.done,      m_done);
      chk("m_busy",      bus.busy,      !m_done);
      chk("m_err",       bus.err,       m_err);
      chk("m_err_stage", bus.err_stage, m_es);
    end
  end

  task automatic to_edge(input int k);
    repeat (k - pos) @(negedge clk);
    pos = k;
  endtask

  task automatic restart_rst(input logic [N-1:0] r);
    rst = 1'b1;
    bus.rdy = r;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pos = 0;
  endtask

  initial begin
    bus.sw_req = 1'b0;
    bus.rdy    = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_rst_o", bus.rst_o, 4'hF);
    chk("rst_done",  bus.done,  1'b0);
    chk("rst_busy",  bus.busy,  1'b1);
    chk("rst_err",   bus.err,   1'b0);
    chk("rst_es",    bus.err_stage, 2'd0);

    // 1: all ready
    rst = 1'b0; pos = 0;
    to_edge(8);  chk("t1_e8",  bus.rst_o, 4'hF);
    to_edge(9);  chk("t1_e9",  bus.rst_o, 4'hE);
    to_edge(27); chk("t1_e27", bus.rst_o, 4'hC);
    to_edge(45); chk("t1_e45", bus.rst_o, 4'h8);
    to_edge(63); chk("t1_e63", bus.rst_o, 4'h0);
    to_edge(80); chk("t1_done80", bus.done, 1'b0);
    to_edge(81); chk("t1_done81", bus.done, 1'b1);
    chk("t1_busy81", bus.busy, 1'b0);
    chk("t1_err", bus.err, 1'b0);

    // 2: late ready on stage 0
    restart_rst(4'h0);
    to_edge(9);  chk("t2_e9", bus.rst_o, 4'hE);
    to_edge(13); bus.rdy = 4'h1;
    to_edge(30); chk("t2_e30", bus.rst_o, 4'hE);
    to_edge(31); chk("t2_e31", bus.rst_o, 4'hC);
    bus.rdy = 4'hF;
    to_edge(131); chk("t2_done", bus.done, 1'b1);

    // 3: stage 2 never ready
    restart_rst(4'b1011);
    to_edge(76);  chk("t3_err76", bus.err, 1'b0);
    to_edge(77);  chk("t3_err77", bus.err, 1'b1);
    chk("t3_es", bus.err_stage, 2'd2);
    to_edge(93);  chk("t3_e93", bus.rst_o, 4'h8);
    to_edge(94);  chk("t3_e94", bus.rst_o, 4'h0);
    to_edge(111); chk("t3_d111", bus.done, 1'b0);
    to_edge(112); chk("t3_d112", bus.done, 1'b1);

    // 4: stages 1 and 2 never ready
    restart_rst(4'b1001);
    to_edge(59);  chk("t4_err59", bus.err, 1'b1);
    chk("t4_es59", bus.err_stage, 2'd1);
    to_edge(108); chk("t4_es108", bus.err_stage, 2'd1);
    to_edge(142); chk("t4_d142", bus.done, 1'b0);
    to_edge(143); chk("t4_d143", bus.done, 1'b1);

    // 5: restart pulse during GAP after stage 1
    restart_rst(4'hF);
    to_edge(30); bus.sw_req = 1'b1;
    to_edge(31); bus.sw_req = 1'b0;
    chk("t5_e31", bus.rst_o, 4'hC);
    to_edge(32);  chk("t5_e32", bus.rst_o, 4'hF);
    chk("t5_done32", bus.done, 1'b0);
    to_edge(40);  chk("t5_e40", bus.rst_o, 4'hF);
    to_edge(41);  chk("t5_e41", bus.rst_o, 4'hE);
    to_edge(112); chk("t5_d112", bus.done, 1'b0);
    to_edge(113); chk("t5_d113", bus.done, 1'b1);

    // 6: held request restarts once; then rst mid-WAIT
    bus.sw_req = 1'b1;
    to_edge(115); chk("t6_e115", bus.rst_o, 4'hF);
    to_edge(313); chk("t6_held_done", bus.done, 1'b1);
    chk("t6_held_busy", bus.busy, 1'b0);
    bus.sw_req = 1'b0;
    bus.rdy    = 4'h0;
    to_edge(320); bus.sw_req = 1'b1;
    to_edge(321); bus.sw_req = 1'b0;
    to_edge(335); chk("t6_wait", bus.rst_o, 4'hE);
    rst = 1'b1;
    to_edge(336); chk("t6_rst_rsto", bus.rst_o, 4'hF);
    chk("t6_rst_done", bus.done, 1'b0);
    chk("t6_rst_busy", bus.busy, 1'b1);
    rst = 1'b0;
    to_edge(360);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
